jt007232_rom_arb: RTL
=====================

JT007232_ROM_ARB -- requirements
Module: jt007232_rom_arb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have no parameters; the only build option is the macro in Configuration.
REQ-003 rst  in  1  async reset, active high
REQ-004 clk  in  1  system clock, sole clock
REQ-005 cha_addr  in  17  channel A byte address
REQ-006 cha_cs  in  1  channel A read request
REQ-007 cha_ok  out  1  channel A data valid for the current cha_addr
REQ-008 cha_dout  out  8  channel A data
REQ-009 chb_addr, chb_cs, chb_ok, chb_dout  SHALL mirror REQ-005..008 for channel B.
REQ-010 mem_addr  out  17  shared memory address
REQ-011 mem_cs  out  1  shared memory request
REQ-012 mem_ok  in  1  shared memory data valid
REQ-013 mem_dout  in  8  shared memory data

Function
REQ-014 SHALL hold, per channel, one demand cache entry: 17-bit tag, 8-bit data, valid bit.
REQ-015 Hit: chX_cs=1, valid=1, tag==chX_addr; chX_ok SHALL then be 1 combinationally, with chX_dout = cached data.
REQ-016 chX_ok SHALL be 0 whenever chX_cs=0 or there is no hit; chX_dout SHALL hold its last value.
REQ-017 Miss: chX_cs=1 and no hit; marks channel X pending.
REQ-018 SHALL implement FSM states IDLE, FETCH_A, FETCH_B.
REQ-019 IDLE, one channel pending: go to that channel's FETCH state next cycle; latch its address into mem_addr; assert mem_cs.
REQ-020 IDLE, both pending: serve the channel opposite the last served (round-robin); the pointer starts at A after reset, so B wins first.
REQ-021 FETCH: mem_ok SHALL be ignored in the first cycle of the state (address settle).
REQ-022 FETCH: from the second cycle, mem_ok=1 SHALL write tag=mem_addr, data=mem_dout, valid=1 into the served channel's entry.
REQ-023 On that same mem_ok cycle: drop mem_cs, update the round-robin pointer, return to IDLE.
REQ-024 Hit data SHALL therefore be visible no earlier than the cycle after mem_ok.
REQ-025 Minimum miss-to-ok latency SHALL be 3 clocks when mem_ok is already high.
REQ-026 mem_addr SHALL stay constant throughout a FETCH state.
REQ-027 A change of chX_addr during a FETCH SHALL NOT abort it; the entry fills with the old address and the new address misses and fetches afterwards.
REQ-028 chX_cs falling during a FETCH SHALL NOT abort it; the fill completes.
REQ-029 A hit on one channel SHALL be served while the other channel's fetch is in flight.
REQ-030 mem_ok while in IDLE SHALL be ignored.

Reset
REQ-031 Reset SHALL give: state IDLE, mem_cs=0, mem_addr=0, cha_dout=chb_dout=0, all valid bits 0, round-robin pointer=A.
REQ-032 Outputs under reset: cha_ok=chb_ok=0.
REQ-033 Reset asserted mid-FETCH SHALL abandon the fetch immediately with no cache write.

Configuration
REQ-034 The prefetch feature SHALL be compiled in only with macro JT007232_ROM_PREFETCH_EN.
REQ-035 Defined: each channel SHALL add a prefetch entry (tag, data, valid) and the FSM SHALL add states PRE_A and PRE_B.
REQ-036 Prefetch start: in IDLE with nothing pending, a channel whose demand entry is valid and whose prefetch tag != demand tag+1 (17-bit wrap) SHALL fetch demand tag+1 into its prefetch entry.
REQ-037 Prefetch timing: same handshake and round-robin as demand fetches.
REQ-038 Prefetch hit: a chX_addr hitting the prefetch entry SHALL assert chX_ok and copy prefetch into demand in the same cycle.
REQ-039 A demand miss arising during a PRE state SHALL wait for the prefetch to complete.
REQ-040 Undefined: no prefetch logic; the block behaves exactly per REQ-014..030.

Verification
REQ-041 Reset, then cha_cs=1, addr=0x00010, mem_ok high with mem_dout=0x5A -> mem_cs rises 1 clk later, cha_ok=1 and cha_dout=0x5A 3 clks after the request.
REQ-042 Both channels miss in the same cycle (A=0x00100, B=0x1FFFF) -> B fetched first, then A; mem_addr 0x1FFFF then 0x00100.
REQ-043 Channel A hit held while B fetch stalls 10 clks on mem_ok=0 -> cha_ok stays 1, chb_ok=0 until 1 clk after mem_ok.
REQ-044 cha_addr changes 0x00020->0x00021 mid-fetch -> fill tag 0x00020, then a second fetch of 0x00021; no abort.
REQ-045 rst pulsed during FETCH_A -> mem_cs=0 at once; a repeat of the same address misses again.
REQ-046 With JT007232_ROM_PREFETCH_EN: after a hit at 0x1FFFF idle -> prefetch of 0x00000; then cha_addr=0x00000 gives cha_ok=1 in the same cycle.

Source files
------------

// File: rtl/jt007232_rom_arb_if.sv
// Shared ROM bus: two read channels plus the single memory port.
interface jt007232_rom_arb_if;
    logic [16:0] cha_addr;
    logic        cha_cs;
    logic        cha_ok;
    logic [7:0]  cha_dout;
    logic [16:0] chb_addr;
    logic        chb_cs;
    logic        chb_ok;
    logic [7:0]  chb_dout;
    logic [16:0] mem_addr;
    logic        mem_cs;
    logic        mem_ok;
    logic [7:0]  mem_dout;

    modport master (
        output cha_addr, cha_cs,
        output chb_addr, chb_cs,
        output mem_ok, mem_dout,
        input  cha_ok, cha_dout,
        input  chb_ok, chb_dout,
        input  mem_addr, mem_cs
    );

    modport slave (
        input  cha_addr, cha_cs,
        input  chb_addr, chb_cs,
        input  mem_ok, mem_dout,
        output cha_ok, cha_dout,
        output chb_ok, chb_dout,
        output mem_addr, mem_cs
    );
endinterface

// File: rtl/jt007232_rom_arb.sv
// Two-channel ROM arbiter with a one-entry cache per channel.
// Define JT007232_ROM_PREFETCH_EN to add next-address prefetch.
module jt007232_rom_arb (
    input logic               clk,
    input logic               rst,
    jt007232_rom_arb_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B
`ifdef JT007232_ROM_PREFETCH_EN
        , PRE_A,
        PRE_B
`endif
    } state_t;

    state_t      st, st_nx;
    logic        settle;
    logic        rr_b;
    logic [16:0] mem_addr_q;
    logic        mem_cs_q;
    logic [16:0] ld_addr;
    logic        fill, srv_b;

    logic [16:0] a_tag, b_tag;
    logic [7:0]  a_data, b_data;
    logic        a_vld, b_vld;
    logic [7:0]  a_dq, b_dq;
    logic        a_dhit, b_dhit;
    logic        a_any, b_any;
    logic        a_hit, b_hit;
    logic        a_pend, b_pend;
    logic [7:0]  a_hdata, b_hdata;

`ifdef JT007232_ROM_PREFETCH_EN
    logic [16:0] a_ptag, b_ptag;
    logic [7:0]  a_pdata, b_pdata;
    logic        a_pvld, b_pvld;
    logic        a_phit, b_phit;
    logic        a_pw, b_pw;

    assign a_phit = a_pvld && a_ptag == bus.cha_addr;
    assign b_phit = b_pvld && b_ptag == bus.chb_addr;
    assign a_pw   = a_vld && (!a_pvld || a_ptag != a_tag + 17'd1);
    assign b_pw   = b_vld && (!b_pvld || b_ptag != b_tag + 17'd1);
    assign a_any  = a_dhit || a_phit;
    assign b_any  = b_dhit || b_phit;
    assign a_hdata = a_dhit ? a_data : a_pdata;
    assign b_hdata = b_dhit ? b_data : b_pdata;
    assign srv_b  = st == FETCH_B || st == PRE_B;
`else
    assign a_any   = a_dhit;
    assign b_any   = b_dhit;
    assign a_hdata = a_data;
    assign b_hdata = b_data;
    assign srv_b   = st == FETCH_B;
`endif

    assign a_dhit = a_vld && a_tag == bus.cha_addr;
    assign b_dhit = b_vld && b_tag == bus.chb_addr;
    assign a_hit  = bus.cha_cs && a_any;
    assign b_hit  = bus.chb_cs && b_any;
    assign a_pend = bus.cha_cs && !a_any;
    assign b_pend = bus.chb_cs && !b_any;

    assign bus.cha_ok   = a_hit;
    assign bus.chb_ok   = b_hit;
    assign bus.cha_dout = a_hit ? a_hdata : a_dq;
    assign bus.chb_dout = b_hit ? b_hdata : b_dq;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_cs   = mem_cs_q;

    // first cycle of a fetch is address settle time
    assign fill = st != IDLE && !settle && bus.mem_ok;

    always_comb begin
        st_nx   = st;
        ld_addr = bus.cha_addr;
        unique case (st)
            IDLE: begin
                if (a_pend && (!b_pend || rr_b)) begin
                    st_nx   = FETCH_A;
                    ld_addr = bus.cha_addr;
                end else if (b_pend) begin
                    st_nx   = FETCH_B;
                    ld_addr = bus.chb_addr;
                end
`ifdef JT007232_ROM_PREFETCH_EN
                else if (a_pw && (!b_pw || rr_b)) begin
                    st_nx   = PRE_A;
                    ld_addr = a_tag + 17'd1;
                end else if (b_pw) begin
                    st_nx   = PRE_B;
                    ld_addr = b_tag + 17'd1;
                end
`endif
            end
            default: begin
                if (fill) st_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            settle     <= 1'b0;
            rr_b       <= 1'b0;
            mem_addr_q <= '0;
            mem_cs_q   <= 1'b0;
        end else begin
            st <= st_nx;
            if (st == IDLE && st_nx != IDLE) begin
                mem_addr_q <= ld_addr;
                mem_cs_q   <= 1'b1;
                settle     <= 1'b1;
            end else begin
                settle <= 1'b0;
            end
            if (fill) begin
                mem_cs_q <= 1'b0;
                rr_b     <= srv_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_tag  <= '0;
            a_data <= '0;
            a_vld  <= 1'b0;
            a_dq   <= '0;
            b_tag  <= '0;
            b_data <= '0;
            b_vld  <= 1'b0;
            b_dq   <= '0;
        end else begin
            a_dq <= bus.cha_dout;
            b_dq <= bus.chb_dout;
            if (fill && st == FETCH_A) begin
                a_tag  <= mem_addr_q;
                a_data <= bus.mem_dout;
                a_vld  <= 1'b1;
            end
            if (fill && st == FETCH_B) begin
                b_tag  <= mem_addr_q;
                b_data <= bus.mem_dout;
                b_vld  <= 1'b1;
            end
`ifdef JT007232_ROM_PREFETCH_EN
            // prefetch hit promotes the entry to demand
            if (bus.cha_cs && a_phit && !a_dhit) begin
                a_tag  <= a_ptag;
                a_data <= a_pdata;
                a_vld  <= 1'b1;
            end
            if (bus.chb_cs && b_phit && !b_dhit) begin
                b_tag  <= b_ptag;
                b_data <= b_pdata;
                b_vld  <= 1'b1;
            end
`endif
        end
    end

`ifdef JT007232_ROM_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ptag  <= '0;
            a_pdata <= '0;
            a_pvld  <= 1'b0;
            b_ptag  <= '0;
            b_pdata <= '0;
            b_pvld  <= 1'b0;
        end else begin
            if (fill && st == PRE_A) begin
                a_ptag  <= mem_addr_q;
                a_pdata <= bus.mem_dout;
                a_pvld  <= 1'b1;
            end
            if (fill && st == PRE_B) begin
                b_ptag  <= mem_addr_q;
                b_pdata <= bus.mem_dout;
                b_pvld  <= 1'b1;
            end
        end
    end
`endif
endmodule
